// File: rtl/porta_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : porta_ctrl_param
//  Description : Parametrised automatic-door controller. Opens on request or
//                emergency, holds open for HOLD_CYC cycles, closes over
//                TRAVEL_CYC cycles, and reverses when an obstacle or a new
//                request appears while closing. Drives motors, LEDs and a
//                7-segment state letter.
//  Revision    : 1.0 - initial release
// ============================================================================
module porta_ctrl_param #(
    parameter int TRAVEL_CYC = 8,   // cycles to fully open or fully close
    parameter int HOLD_CYC   = 20,  // cycles held open before auto-close
    parameter int CNT_W      = 16   // counter width
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       abrir,
    input  logic       fechar,
    input  logic       sensor,
    input  logic       trava,
    input  logic       emergencia,
    output logic [1:0] estado,
    output logic       motor_abre,
    output logic       motor_fecha,
    output logic       led_verde,
    output logic       led_vermelho,
    output logic [6:0] hex,
    output logic       evt_reversao
);

    // Last counter value of a travel phase and of the open hold phase.
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

    // Active-low 7-segment codes {g..a} for the state letters.
    localparam logic [6:0] HEX_F = 7'b0001110;
    localparam logic [6:0] HEX_O = 7'b1000000;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_C = 7'b1000110;

    typedef enum logic [1:0] {
        FECHADO  = 2'b00,
        ABRINDO  = 2'b01,
        ABERTO   = 2'b10,
        FECHANDO = 2'b11
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             keep_open;

    // Anything that demands the doorway be (or stay) clear.
    always_comb begin
        keep_open = emergencia | sensor | abrir;
    end

    // Door state machine with its phase counter and reversal pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FECHADO;
            cnt          <= '0;
            evt_reversao <= 1'b0;
        end else begin
            evt_reversao <= 1'b0;
            case (state)
                FECHADO: begin
                    cnt <= '0;
                    // Emergency overrides the lock; a plain request does not.
                    if (emergencia || (abrir && !trava)) begin
                        state <= ABRINDO;
                    end
                end
                ABRINDO: begin
                    // Opening cannot be interrupted; only travel time matters.
                    if (cnt == TRAVEL_LAST) begin
                        state <= ABERTO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ABERTO: begin
                    if (keep_open) begin
                        cnt <= '0;
                    end else if (fechar) begin
                        state <= FECHANDO;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= FECHANDO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FECHANDO: begin
                    // Reverse from the current position: the remaining
                    // opening distance equals what has already been closed.
                    if (keep_open) begin
                        state        <= ABRINDO;
                        cnt          <= TRAVEL_LAST - cnt;
                        evt_reversao <= 1'b1;
                    end else if (cnt == TRAVEL_LAST) begin
                        state <= FECHADO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= FECHADO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register, so an
    // asynchronous reset drops the motors without waiting for a clock.
    always_comb begin
        estado       = state;
        motor_abre   = (state == ABRINDO);
        motor_fecha  = (state == FECHANDO);
        led_verde    = (state == ABERTO);
        led_vermelho = (state == FECHADO);
        case (state)
            FECHADO:  hex = HEX_F;
            ABRINDO:  hex = HEX_O;
            ABERTO:   hex = HEX_A;
            FECHANDO: hex = HEX_C;
            default:  hex = HEX_F;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_porta_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_porta_ctrl_param
//  Description : Self-checking bench for porta_ctrl_param (TRAVEL_CYC=4,
//                HOLD_CYC=6) using a countdown-based door model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_porta_ctrl_param;

    localparam int T = 4;
    localparam int H = 6;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       abrir, fechar, sensor, trava, emergencia;
    logic [1:0] estado;
    logic       motor_abre, motor_fecha, led_verde, led_vermelho, evt_reversao;
    logic [6:0] hex;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 closed, 1 opening, 2 open, 3 closing; rem = cycles left
    // in a travel phase; hold = cycles left before auto-close.
    int m_phase, m_rem, m_hold;
    logic m_evt;

    porta_ctrl_param #(.TRAVEL_CYC(T), .HOLD_CYC(H), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .abrir(abrir), .fechar(fechar),
        .sensor(sensor), .trava(trava), .emergencia(emergencia),
        .estado(estado), .motor_abre(motor_abre), .motor_fecha(motor_fecha),
        .led_verde(led_verde), .led_vermelho(led_vermelho), .hex(hex),
        .evt_reversao(evt_reversao)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] letter(input int ph);
        case (ph)
            0: letter = 7'b0001110;
            1: letter = 7'b1000000;
            2: letter = 7'b0001000;
            default: letter = 7'b1000110;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_hold = 0; m_evt = 1'b0;
    endtask

    task automatic model_edge(input logic a, f, s, t, e);
        m_evt = 1'b0;
        case (m_phase)
            0: if (e || (a && !t)) begin m_phase = 1; m_rem = T; end
            1: begin
                m_rem--;
                if (m_rem == 0) begin m_phase = 2; m_hold = H; end
            end
            2: begin
                if (e || s || a) m_hold = H;
                else if (f) begin m_phase = 3; m_rem = T; end
                else begin
                    m_hold--;
                    if (m_hold == 0) begin m_phase = 3; m_rem = T; end
                end
            end
            default: begin
                if (s || a || e) begin
                    // closed so far = T - m_rem; reopening takes that plus one
                    m_rem = T - m_rem + 1; m_phase = 1; m_evt = 1'b1;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ":estado"}, 32'(estado), 32'(m_phase));
        chk({tag, ":hex"}, 32'(hex), 32'(letter(m_phase)));
        chk({tag, ":flags"},
            32'({motor_abre, motor_fecha, led_verde, led_vermelho, evt_reversao}),
            32'({m_phase == 1, m_phase == 3, m_phase == 2, m_phase == 0, m_evt}));
    endtask

    task automatic step(input string tag, input logic a, f, s, t, e);
        @(negedge clock);
        abrir = a; fechar = f; sensor = s; trava = t; emergencia = e;
        @(posedge clock);
        model_edge(a, f, s, t, e);
        #1;
        compare_all(tag);
    endtask

    // Counts cycles the DUT spends in phase st (including the current one).
    task automatic count_phase(input string tag, input logic [1:0] st, output int n);
        n = 0;
        while (estado == st && n < 60) begin
            n++;
            step(tag, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic wait_closed(input string tag);
        int n;
        n = 0;
        while (estado != 2'b00 && n < 60) begin
            n++;
            step(tag, 0, 0, 0, 0, 0);
        end
        chk({tag, ":closed"}, 32'(estado), 32'd0);
    endtask

    initial begin
        int n;
        abrir = 0; fechar = 0; sensor = 0; trava = 0; emergencia = 0;
        reset_n = 1'b0;
        model_reset();
        #12;
        // Reset values
        chk("rst:estado", 32'(estado), 32'd0);
        chk("rst:hex", 32'(hex), 32'b0001110);
        chk("rst:flags", 32'({motor_abre, motor_fecha, led_verde, led_vermelho, evt_reversao}), 32'b00010);
        @(negedge clock);
        reset_n = 1'b1;

        // Full cycle from a single-cycle request
        step("t2:req", 1, 0, 0, 0, 0);
        chk("t2:opening", 32'(estado), 32'd1);
        count_phase("t2:abr", 2'b01, n); chk("t2:len_abrindo", 32'(n), 32'(T));
        count_phase("t2:abt", 2'b10, n); chk("t2:len_aberto", 32'(n), 32'(H));
        count_phase("t2:fch", 2'b11, n); chk("t2:len_fechando", 32'(n), 32'(T));
        chk("t2:end", 32'(estado), 32'd0);

        // Lock blocks opening; emergency overrides and keeps open
        for (int i = 0; i < 10; i++) step("t3:lock", 1, 0, 0, 1, 0);
        chk("t3:locked", 32'(estado), 32'd0);
        step("t3:emerg", 1, 0, 0, 1, 1);
        chk("t3:emerg_open", 32'(estado), 32'd1);
        for (int i = 0; i < 30; i++) step("t3:hold", 0, 1, 0, 0, 1);
        chk("t3:still_open", 32'(estado), 32'd2);
        count_phase("t3:rel", 2'b10, n); chk("t3:hold_after_emerg", 32'(n), 32'(H));
        wait_closed("t3");

        // Obstacle during closing at cnt=1
        step("t4:req", 1, 0, 0, 0, 0);
        while (estado != 2'b11 && n < 200) begin n++; step("t4:go", 0, 0, 0, 0, 0); end
        step("t4:c1", 0, 0, 0, 0, 0);
        step("t4:obst", 0, 0, 1, 0, 0);
        chk("t4:rev_state", 32'(estado), 32'd1);
        chk("t4:evt", 32'(evt_reversao), 32'd1);
        count_phase("t4:reopen", 2'b01, n); chk("t4:reopen_len", 32'(n), 32'd2);
        count_phase("t4:hold", 2'b10, n); chk("t4:hold_len", 32'(n), 32'(H));
        wait_closed("t4");

        // Sensor holds the door; fechar closes early
        step("t5:req", 1, 0, 0, 0, 0);
        n = 0;
        while (estado != 2'b10 && n < 20) begin n++; step("t5:go", 0, 0, 0, 0, 0); end
        for (int i = 0; i < 15; i++) step("t5:sens", 0, 0, 1, 0, 0);
        chk("t5:held", 32'(estado), 32'd2);
        count_phase("t5:rel", 2'b10, n); chk("t5:close_delay", 32'(n), 32'(H));
        step("t5:reopen", 1, 0, 0, 0, 0);
        n = 0;
        while (estado != 2'b10 && n < 20) begin n++; step("t5:go2", 0, 0, 0, 0, 0); end
        step("t5:fechar", 0, 1, 0, 0, 0);
        chk("t5:fechar_now", 32'(estado), 32'd3);
        wait_closed("t5");

        // Asynchronous reset in the middle of opening
        step("t6:req", 1, 0, 0, 0, 0);
        step("t6:mid", 0, 0, 0, 0, 0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6:estado", 32'(estado), 32'd0);
        chk("t6:motor_abre", 32'(motor_abre), 32'd0);
        chk("t6:vermelho", 32'(led_vermelho), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step("rnd",
                 ($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
                 ($urandom % 3) == 0, ($urandom % 25) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
